// File: rtl/vga_rect_fill_pkg.sv
// Shared screen geometry, FSM state encoding and span clipping for pixel engines.
// Latency: none (constants, types and a combinational helper function).
// Backpressure: none.
package vga_pkg;

  localparam int SCREEN_W = 160;  // visible columns, X in 0..SCREEN_W-1
  localparam int SCREEN_H = 120;  // visible rows,    Y in 0..SCREEN_H-1
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result of clipping one axis of a primitive against the screen.
  typedef struct packed {
    logic       empty;  // nothing of this span is visible
    logic [7:0] last;   // last visible coordinate (valid only when !empty)
  } span_t;

  // Clip [org, org+len) against [0, lim). The end is formed one bit wider
  // than the operands so a large origin plus length never wraps back onto
  // the screen.
  function automatic span_t clip_span(input logic [7:0] org,
                                      input logic [7:0] len,
                                      input logic [8:0] lim);
    logic [8:0] stop;
    span_t      s;
    stop = {1'b0, org} + {1'b0, len};
    if (stop > lim) begin
      stop = lim;
    end
    s.empty = (len == 8'd0) || ({1'b0, org} >= lim);
    s.last  = 8'(stop - 9'd1);
    return s;
  endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Request/plot bundle between rectangle-fill user logic and the plot sequencer.
// Latency: none (wires only).
// Backpressure: hold stalls the pixel stream; start is dropped while busy.
//   master: drives start/hold/x0/y0/w/h/color, observes VGA_X/VGA_Y/VGA_COLOR/plot/busy/done
//   slave : the sequencer side (vga_rect_fill)
interface vga_rect_fill_if;
  import vga_pkg::*;

  logic          start;
  logic          hold;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [7:0]    w;
  logic [6:0]    h;
  logic [CW-1:0] color;

  logic [XW-1:0] VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [CW-1:0] VGA_COLOR;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, hold, x0, y0, w, h, color,
    input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
  );

  modport slave (
    input  start, hold, x0, y0, w, h, color,
    output VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
  );

endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill sequencer: latches a clipped rectangle and emits one plot strobe per pixel, raster order.
// Latency: first pixel one cycle after start is accepted, then one pixel per cycle; done one cycle after the last pixel.
// Backpressure: hold freezes the cursor and drops plot; start is only sampled in IDLE (never queued).
//   CLOCK_50 / Resetn : clock and asynchronous active-low reset
//   bus (slave)       : start/hold/x0/y0/w/h/color in; VGA_X/VGA_Y/VGA_COLOR/plot/busy/done out (all registered)
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           Resetn,
  vga_rect_fill_if.slave bus
);

  state_t        state_q, state_d;
  logic [XW-1:0] x0_q, x0_d;      // left column, reloaded into cx at each new row
  logic [XW-1:0] xe_q, xe_d;      // last visible column
  logic [7:0]    ye_q, ye_d;      // last visible row (kept 8 bits, top bit always 0)
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [CW-1:0] col_q, col_d;
  logic [XW-1:0] vga_x_q, vga_x_d;
  logic [YW-1:0] vga_y_q, vga_y_d;
  logic [CW-1:0] vga_color_q, vga_color_d;
  logic          plot_q, plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  span_t         xs, ys;

  always_comb begin
    xs = clip_span(bus.x0, bus.w, 9'(SCREEN_W));
    ys = clip_span({1'b0, bus.y0}, {1'b0, bus.h}, 9'(SCREEN_H));

    state_d     = state_q;
    x0_d        = x0_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    col_d       = col_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    plot_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          x0_d  = bus.x0;
          cx_d  = bus.x0;
          cy_d  = bus.y0;
          col_d = bus.color;
          xe_d  = xs.last;
          ye_d  = ys.last;
          // An empty rectangle still produces a done pulse, but never busy.
          state_d = (xs.empty || ys.empty) ? DONE : PLOT;
        end
      end

      PLOT: begin
        busy_d = 1'b1;
        if (!bus.hold) begin
          vga_x_d     = cx_q;
          vga_y_d     = cy_q;
          vga_color_d = col_q;
          plot_d      = 1'b1;
          if (cx_q < xe_q) begin
            cx_d = cx_q + 8'd1;
          end else if ({1'b0, cy_q} < ye_q) begin
            cx_d = x0_q;
            cy_d = cy_q + 7'd1;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      xe_q        <= '0;
      ye_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      col_q       <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      col_q       <= col_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.VGA_X     = vga_x_q;
  assign bus.VGA_Y     = vga_y_q;
  assign bus.VGA_COLOR = vga_color_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: expected pixels queued at start, popped on each plot strobe.
// Latency: n/a (testbench).
// Backpressure: hold driven from a per-cycle mask.
module tb_vga_rect_fill;
  import vga_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_rect_fill_if bus ();

  vga_rect_fill dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pix(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    return (x << 10) | (y << 3) | c;
  endfunction

  function automatic logic [31:0] out_pix();
    return pix(32'(bus.VGA_X), 32'(bus.VGA_Y), 32'(bus.VGA_COLOR));
  endfunction

  // Runs one rectangle. Cycle k means the outputs seen just after edge k
  // (edge 0 accepts start); hold_mask[k] is the hold level sampled at edge k.
  // With pester set, a conflicting start is raised mid-fill and again in the
  // done cycle; both must be ignored.
  task automatic run_rect(input string name, input int x0, input int y0, input int w,
                          input int h, input int c, input logic [63:0] hold_mask,
                          input bit pester);
    int  xe, ye, n, plotted, exp_done, last_pix;
    bit  empty, exp_plot, hmask;
    empty = (w == 0) || (h == 0) || (x0 >= SCREEN_W) || (y0 >= SCREEN_H);
    xe = ((x0 + w) < SCREEN_W ? x0 + w : SCREEN_W) - 1;
    ye = ((y0 + h) < SCREEN_H ? y0 + h : SCREEN_H) - 1;
    exp_q.delete();
    n = 0;
    last_pix = 0;
    if (!empty) begin
      for (int yy = y0; yy <= ye; yy++) begin
        for (int xx = x0; xx <= xe; xx++) begin
          last_pix = pix(xx, yy, c);
          exp_q.push_back(last_pix);
          n++;
        end
      end
    end
    if (empty) begin
      exp_done = 1;
    end else begin
      plotted = 0;
      exp_done = 1;
      while (plotted < n) begin
        if (!(exp_done < 64 && hold_mask[exp_done])) plotted++;
        exp_done++;
      end
    end

    @(negedge CLOCK_50);
    bus.x0    = 8'(x0);
    bus.y0    = 7'(y0);
    bus.w     = 8'(w);
    bus.h     = 7'(h);
    bus.color = 3'(c);
    bus.start = 1'b1;
    bus.hold  = hold_mask[0];
    @(posedge CLOCK_50);

    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      @(negedge CLOCK_50);
      hmask     = (cyc < 64) ? hold_mask[cyc] : 1'b0;
      bus.start = 1'b0;
      bus.hold  = hmask;
      if (pester && (cyc == 2 || cyc == exp_done)) begin
        bus.start = 1'b1;
        bus.color = 3'(~c);
        bus.x0    = 8'd0;
        bus.w     = 8'd50;
      end
      @(posedge CLOCK_50);
      #1;
      exp_plot = !empty && (cyc < exp_done) && !hmask;
      check({name, ":plot"}, 32'(bus.plot), 32'(exp_plot));
      check({name, ":busy"}, 32'(bus.busy), 32'(!empty && cyc < exp_done));
      check({name, ":done"}, 32'(bus.done), 32'(cyc == exp_done));
      if (bus.plot === 1'b1) begin
        if (exp_q.size() == 0) check({name, ":extra_pixel"}, out_pix(), 32'hFFFF_FFFF);
        else check({name, ":pixel"}, out_pix(), exp_q.pop_front());
      end
    end
    bus.start = 1'b0;
    check({name, ":missing_pixels"}, 32'(exp_q.size()), 32'd0);
    if (!empty) check({name, ":idle_retains_xyc"}, out_pix(), last_pix);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.w     = '0;
    bus.h     = '0;
    bus.color = '0;

    #12;
    check("rst:plot",  32'(bus.plot), 0);
    check("rst:busy",  32'(bus.busy), 0);
    check("rst:done",  32'(bus.done), 0);
    check("rst:xyc",   out_pix(), 0);
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    run_rect("basic",     10,   5,   3, 2, 5, 64'h0, 1'b0);
    run_rect("clip",      158, 118,  5, 4, 3, 64'h1, 1'b0);
    run_rect("empty_w",   20,  20,   0, 4, 1, 64'h0, 1'b0);
    run_rect("empty_x",   200, 10,   4, 4, 2, 64'h0, 1'b0);
    run_rect("empty_h",   5,   5,    3, 0, 7, 64'h0, 1'b0);
    run_rect("empty_y",   5,   125,  3, 2, 7, 64'h0, 1'b0);
    run_rect("hold",      0,   0,    2, 1, 6, 64'hE, 1'b0);
    run_rect("hold_mid",  50,  60,   3, 3, 1, 64'h0000_0000_0000_0A50, 1'b0);
    run_rect("busy_start",30,  40,   4, 3, 2, 64'h0, 1'b1);
    run_rect("wide_row",  0,   119, 255, 1, 4, 64'h0, 1'b0);

    // Reset in the middle of a 10x10 fill.
    exp_q.delete();
    @(negedge CLOCK_50);
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd10; bus.h = 7'd10;
    bus.color = 3'd4; bus.hold = 1'b0; bus.start = 1'b1;
    @(posedge CLOCK_50);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge CLOCK_50);
      bus.start = 1'b0;
      @(posedge CLOCK_50);
      #1;
      check("rstmid:plot",  32'(bus.plot), 1);
      check("rstmid:pixel", out_pix(), pix(cyc - 1, 0, 4));
    end
    #2;
    Resetn = 1'b0;
    #1;
    check("rstmid:async_plot", 32'(bus.plot), 0);
    check("rstmid:async_busy", 32'(bus.busy), 0);
    check("rstmid:async_done", 32'(bus.done), 0);
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge CLOCK_50);
      #1;
      check("rstmid:after_plot", 32'(bus.plot), 0);
      check("rstmid:after_done", 32'(bus.done), 0);
      check("rstmid:after_busy", 32'(bus.busy), 0);
    end

    // The sequencer must be usable again after the mid-fill reset.
    run_rect("post_reset", 7, 3, 2, 2, 3, 64'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Sequencer for the pixel-plot port (VGA_X / VGA_Y / VGA_COLOR / plot) of the 160x120, 3-bit-colour framebuffer.
- On a start pulse it latches a rectangle (origin, width, height, colour) and emits one plot strobe per pixel in raster order.
- Clips the rectangle to the screen edges and reports busy/done.
- Sits between user logic (SW/KEY decode or game FSM) and the plot outputs of Top.

Parameters:
- SCREEN_W, 160, visible columns; X coordinates 0..SCREEN_W-1.
- SCREEN_H, 120, visible rows; Y coordinates 0..SCREEN_H-1.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- hold  in  1  stall; while high no pixel advances and plot=0.
- x0  in  8  rectangle left column.
- y0  in  7  rectangle top row.
- w  in  8  width in pixels, 0..255.
- h  in  7  height in pixels, 0..127.
- color  in  3  fill colour.
- VGA_X  out  8  current pixel column.
- VGA_Y  out  7  current pixel row.
- VGA_COLOR  out  3  latched colour.
- plot  out  1  pixel strobe; one cycle per pixel.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, Resetn=0): state=IDLE; VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, busy=0, done=0.
- All outputs are registered.

FSM states:
- IDLE: on start=1, latch x0/y0/color and compute the clipped end coordinates.
  - xe = min(x0+w, SCREEN_W)-1; x0+w is evaluated in 9 bits, with no wrap.
  - ye = min(y0+h, SCREEN_H)-1; y0+h is evaluated in 8 bits, with no wrap.
  - Rectangle is empty if w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H. Empty -> DONE; otherwise -> PLOT with cursor (cx,cy)=(x0,y0).
- PLOT:
  - Each cycle with hold=0: VGA_X<=cx, VGA_Y<=cy, VGA_COLOR<=latched colour, plot<=1, then advance the cursor.
    - If cx<xe: cx+1.
    - Else if cy<ye: cx=x0, cy+1.
    - Else -> DONE.
  - Cycles with hold=1: plot<=0; cursor and VGA_X/Y/COLOR hold their values.
- DONE: done=1 for exactly one cycle, busy<=0, -> IDLE; plot=0.

Timing:
- Start accepted at edge 0 (start=1 sampled there).
- busy=1 from cycle 1.
- With hold=0, pixels are presented in cycles 1..N, where N=(xe-x0+1)*(ye-y0+1).
- done pulses in cycle N+1; busy=0 from cycle N+1.
- Empty rectangle: no plot; done in cycle 1; busy stays 0.

Edge rules:
- start while busy, or in the DONE cycle: ignored, not queued.
- Inputs x0/y0/w/h/color may change after acceptance without effect.
- hold in IDLE or DONE: no effect.
- Reset mid-PLOT: immediate return to IDLE, plot=0, no done pulse.
- VGA_X/Y/COLOR retain their last plotted values in IDLE, so the sink sees no spurious strobe.

Decomposition:
- Shared package vga_pkg:
  - constants SCREEN_W, SCREEN_H, XW=8, YW=7, CW=3;
  - state enum {IDLE, PLOT, DONE}.
- No sub-module needed. The clip computation is a function in vga_pkg so a future line/sprite engine can reuse it.

Test Plan:
1. x0=10,y0=5,w=3,h=2,color=5, start at edge 0, hold=0 -> plot in cycles 1..6 at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), colour 5; done=1 in cycle 7 only; busy=1 in cycles 1..6.
2. Clip: x0=158,y0=118,w=5,h=4 -> exactly 4 plots: (158,118),(159,118),(158,119),(159,119); done in cycle 5.
3. Empty: w=0 (and separately x0=200) -> plot never asserted; done in cycle 1; busy stays 0.
4. Hold: 2x1 rect at (0,0), hold=1 in cycles 1-3 -> plot=0 in cycles 1-3; (0,0) in cycle 4, (1,0) in cycle 5; done in cycle 6.
5. Start while busy: second start with different colour during PLOT -> ignored; pixel count and colour unchanged; one done.
6. Reset mid-op: Resetn=0 after the 3rd pixel of a 10x10 rect -> plot/busy/done drop to 0 asynchronously; after release, no further plots until a new start.
